print_arbiter: RTL and testbench

//   Shares the single serial print engine between N requesters (DCP command handlers).

---
 rtl/print_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_print_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/print_arbiter.sv
// print_arbiter
//   Round-robin arbiter that shares one serial print engine between N DCP
//   command handlers. The winning requester's payload and type are latched
//   at grant and held stable on dout_tx/type_tx while req_tx is high. The
//   requester then gets a one-cycle ack when the engine answers, or a
//   one-cycle err if the engine stays silent for TIMEOUT cycles. Between
//   grants req_tx is held low, so the engine always sees a fresh rising edge.
//
// Ports
//   clk      in   1          system clock
//   rst      in   1          synchronous reset, active-high
//   req      in   N          per-requester level request
//   din      in   32*N       payloads, requester i on din[32*i+31:32*i]
//   typ      in   N          per-requester type, 0=byte 1=word
//   ack      out  N          one-cycle completion pulse to the granted requester
//   err      out  N          one-cycle timeout pulse to the granted requester
//   busy     out  1          high while waiting on the engine or in the gap
//   gnt_id   out  $clog2(N)  index of the current/last granted requester
//   req_tx   out  1          request to the print engine
//   dout_tx  out  32         payload to the print engine
//   type_tx  out  1          type to the print engine
//   ack_tx   in   1          completion from the print engine
module print_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1048576,
    parameter int GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [32*N-1:0]       din,
    input  logic [N-1:0]          typ,
    output logic [N-1:0]          ack,
    output logic [N-1:0]          err,
    output logic                  busy,
    output logic [$clog2(N)-1:0]  gnt_id,
    output logic                  req_tx,
    output logic [31:0]           dout_tx,
    output logic                  type_tx,
    input  logic                  ack_tx
);

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IW-1:0] LAST_ID  = IW'(N - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Next index after id, wrapping at N-1 (N need not be a power of two).
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] id);
        if (id == LAST_ID) begin
            wrap_inc = {IW{1'b0}};
        end else begin
            wrap_inc = id + IW'(1);
        end
    endfunction

    state_t          state_r, state_s;
    logic [IW-1:0]   ptr_r, ptr_s;
    logic [TW-1:0]   tmr_r, tmr_s;
    logic [GW-1:0]   gap_r, gap_s;
    logic [N-1:0]    ack_r, ack_s;
    logic [N-1:0]    err_r, err_s;
    logic            busy_r, busy_s;
    logic [IW-1:0]   gnt_r, gnt_s;
    logic            req_tx_r, req_tx_s;
    logic [31:0]     dout_r, dout_s;
    logic            type_r, type_s;

    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic [31:0]     pick_din_s;
    logic            pick_typ_s;
    int              idx_s;

    // Round-robin search: first requester at or above ptr, wrapping modulo N.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = int'(ptr_r) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = IW'(idx_s);
            end else begin
                pick_s  = pick_s;
            end
        end
        pick_din_s = din[{pick_s, 5'd0} +: 32];
        pick_typ_s = typ[pick_s];
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        tmr_s    = tmr_r;
        gap_s    = gap_r;
        ack_s    = {N{1'b0}};
        err_s    = {N{1'b0}};
        gnt_s    = gnt_r;
        req_tx_s = req_tx_r;
        dout_s   = dout_r;
        type_s   = type_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_s    = pick_s;
                    dout_s   = pick_din_s;
                    type_s   = pick_typ_s;
                    req_tx_s = 1'b1;
                    tmr_s    = {TW{1'b0}};
                    state_s  = ST_WAIT;
                end else begin
                    req_tx_s = 1'b0;
                end
            end
            ST_WAIT: begin
                tmr_s = tmr_r + TW'(1);
                // An engine answer on the last allowed cycle still counts as success.
                if (ack_tx) begin
                    req_tx_s     = 1'b0;
                    ack_s[gnt_r] = 1'b1;
                    ptr_s        = wrap_inc(gnt_r);
                    gap_s        = GAP_LOAD;
                    state_s      = ST_HOLD;
                end else if (tmr_r == TMR_LAST) begin
                    req_tx_s     = 1'b0;
                    err_s[gnt_r] = 1'b1;
                    ptr_s        = wrap_inc(gnt_r);
                    gap_s        = GAP_LOAD;
                    state_s      = ST_HOLD;
                end else begin
                    req_tx_s     = 1'b1;
                end
            end
            ST_HOLD: begin
                // Keeps req_tx low long enough for the engine to see a new rising edge.
                req_tx_s = 1'b0;
                if (gap_r == {GW{1'b0}}) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r - GW'(1);
                end
            end
            default: begin
                req_tx_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {IW{1'b0}};
            tmr_r    <= {TW{1'b0}};
            gap_r    <= {GW{1'b0}};
            ack_r    <= {N{1'b0}};
            err_r    <= {N{1'b0}};
            busy_r   <= 1'b0;
            gnt_r    <= {IW{1'b0}};
            req_tx_r <= 1'b0;
            dout_r   <= 32'h0000_0000;
            type_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            tmr_r    <= tmr_s;
            gap_r    <= gap_s;
            ack_r    <= ack_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
            gnt_r    <= gnt_s;
            req_tx_r <= req_tx_s;
            dout_r   <= dout_s;
            type_r   <= type_s;
        end
    end

    assign ack     = ack_r;
    assign err     = err_r;
    assign busy    = busy_r;
    assign gnt_id  = gnt_r;
    assign req_tx  = req_tx_r;
    assign dout_tx = dout_r;
    assign type_tx = type_r;

endmodule

// File: tb/tb_print_arbiter.sv
// Self-checking bench for print_arbiter (N=4, TIMEOUT=16, GAP=2).
// Directed table of transactions with hand-computed grant order, a mid-transfer
// reset sequence, then randomized traffic checked against a transaction-level
// round-robin model.
module tb_print_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req;
    logic [32*N-1:0] din;
    logic [N-1:0]    typ;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic            busy;
    logic [1:0]      gnt_id;
    logic            req_tx;
    logic [31:0]     dout_tx;
    logic            type_tx;
    logic            ack_tx = 1'b0;

    logic [31:0]     din_arr [N];
    logic [31:0]     din_init [N];
    logic [N-1:0]    req_v = 4'b0000;
    logic [N-1:0]    typ_v = 4'b0000;
    logic [N-1:0]    typ_init;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        int         delay;
        int         exp_gnt;
        bit         exp_to;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    assign req = req_v;
    assign typ = typ_v;

    // Pack per-requester payloads onto the flat din bus.
    always_comb begin
        din = {(32*N){1'b0}};
        for (int i = 0; i < N; i++) begin
            din[32*i +: 32] = din_arr[i];
        end
    end

    print_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .typ     (typ),
        .ack     (ack),
        .err     (err),
        .busy    (busy),
        .gnt_id  (gnt_id),
        .req_tx  (req_tx),
        .dout_tx (dout_tx),
        .type_tx (type_tx),
        .ack_tx  (ack_tx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reset pulse with all requests dropped; checks the cleared outputs.
    task automatic reset_pulse(input string tag);
        req_v  = 4'b0000;
        ack_tx = 1'b0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        chk({tag, ".req_tx"},  64'(req_tx),  64'd0);
        chk({tag, ".busy"},    64'(busy),    64'd0);
        chk({tag, ".ack"},     64'(ack),     64'd0);
        chk({tag, ".err"},     64'(err),     64'd0);
        chk({tag, ".gnt_id"},  64'(gnt_id),  64'd0);
        chk({tag, ".dout_tx"}, 64'(dout_tx), 64'd0);
        chk({tag, ".type_tx"}, 64'(type_tx), 64'd0);
    endtask

    // From IDLE with req driven: one edge later the grant must be on the engine port.
    task automatic grant(input int g, input logic [31:0] exp_dout, input logic exp_typ, input string tag);
        step();
        chk({tag, ".gnt.req_tx"},  64'(req_tx),  64'd1);
        chk({tag, ".gnt.gnt_id"},  64'(gnt_id),  64'(g));
        chk({tag, ".gnt.dout_tx"}, 64'(dout_tx), 64'(exp_dout));
        chk({tag, ".gnt.type_tx"}, 64'(type_tx), 64'(exp_typ));
        chk({tag, ".gnt.busy"},    64'(busy),    64'd1);
        chk({tag, ".gnt.ackerr"},  64'({ack, err}), 64'd0);
    endtask

    // Engine answers on the cycle with tmr==delay (never if delay>=TIMEOUT).
    // Corrupts the granted payload mid-wait, then walks the gap back to IDLE.
    task automatic complete(input int delay, input int g, input logic [31:0] exp_dout,
                            input logic exp_typ, input bit exp_to, input string tag);
        logic [31:0]  saved_d;
        logic         saved_t;
        logic [N-1:0] one;
        logic [N-1:0] oh;
        int           end_t;
        one     = 4'b0001;
        oh      = one << g;
        saved_d = din_arr[g];
        saved_t = typ_v[g];
        end_t   = exp_to ? TIMEOUT - 1 : delay;
        for (int t = 0; t <= end_t; t++) begin
            if (t == 1) begin
                din_arr[g] = ~saved_d;
                typ_v[g]   = ~saved_t;
            end
            ack_tx = (t == delay);
            step();
            ack_tx = 1'b0;
            chk($sformatf("%s.w%0d.dout_tx", tag, t), 64'(dout_tx), 64'(exp_dout));
            chk($sformatf("%s.w%0d.type_tx", tag, t), 64'(type_tx), 64'(exp_typ));
            if (t < end_t) begin
                chk($sformatf("%s.w%0d.req_tx", tag, t), 64'(req_tx), 64'd1);
                chk($sformatf("%s.w%0d.ackerr", tag, t), 64'({ack, err}), 64'd0);
            end else begin
                chk({tag, ".done.req_tx"}, 64'(req_tx), 64'd0);
                chk({tag, ".done.ack"},    64'(ack),    exp_to ? 64'd0 : 64'(oh));
                chk({tag, ".done.err"},    64'(err),    exp_to ? 64'(oh) : 64'd0);
                chk({tag, ".done.busy"},   64'(busy),   64'd1);
            end
        end
        req_v[g]   = 1'b0;
        din_arr[g] = saved_d;
        typ_v[g]   = saved_t;
        for (int h = 1; h <= GAP; h++) begin
            ack_tx = 1'($urandom_range(0, 1));
            step();
            chk($sformatf("%s.h%0d.req_tx", tag, h), 64'(req_tx), 64'd0);
            chk($sformatf("%s.h%0d.ackerr", tag, h), 64'({ack, err}), 64'd0);
            chk($sformatf("%s.h%0d.busy", tag, h),   64'(busy), (h < GAP) ? 64'd1 : 64'd0);
            chk($sformatf("%s.h%0d.dout", tag, h),   64'(dout_tx), 64'(exp_dout));
        end
    endtask

    initial begin
        int ptr_m;
        int win;
        int dly;
        bit found;
        logic [N-1:0] new_bits;

        din_init[0] = 32'h1111_0000;
        din_init[1] = 32'h0000_00A5;
        din_init[2] = 32'h2222_2222;
        din_init[3] = 32'h3333_3333;
        typ_init    = 4'b1000;
        for (int i = 0; i < N; i++) din_arr[i] = din_init[i];
        typ_v = typ_init;

        //           rst   req      delay gnt timeout
        vecs[0] = '{1'b0, 4'b0010,  5,   1,  1'b0};
        vecs[1] = '{1'b1, 4'b1011,  0,   0,  1'b0};
        vecs[2] = '{1'b0, 4'b1011,  3,   1,  1'b0};
        vecs[3] = '{1'b0, 4'b1011,  1,   3,  1'b0};
        vecs[4] = '{1'b0, 4'b1011, 15,   0,  1'b0};
        vecs[5] = '{1'b0, 4'b1011,  2,   1,  1'b0};
        vecs[6] = '{1'b0, 4'b1011,  7,   3,  1'b0};
        vecs[7] = '{1'b0, 4'b0100, 99,   2,  1'b1};
        vecs[8] = '{1'b0, 4'b1110,  4,   3,  1'b0};
        vecs[9] = '{1'b0, 4'b0110,  6,   1,  1'b0};

        step();
        reset_pulse("init");

        for (int r = 0; r < 10; r++) begin
            if (vecs[r].do_rst) reset_pulse($sformatf("v%0d.rst", r));
            req_v = vecs[r].req;
            grant(vecs[r].exp_gnt, din_init[vecs[r].exp_gnt], typ_init[vecs[r].exp_gnt],
                  $sformatf("v%0d", r));
            complete(vecs[r].delay, vecs[r].exp_gnt, din_init[vecs[r].exp_gnt],
                     typ_init[vecs[r].exp_gnt], vecs[r].exp_to, $sformatf("v%0d", r));
        end

        // Reset in the middle of a transfer: pointer returns to 0, no pulse issued.
        req_v = 4'b1010;
        grant(3, din_init[3], typ_init[3], "mrst");
        ack_tx = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst.req_tx", 64'(req_tx), 64'd0);
        chk("mrst.busy",   64'(busy),   64'd0);
        chk("mrst.ackerr", 64'({ack, err}), 64'd0);
        grant(1, din_init[1], typ_init[1], "mrst.re");
        complete(2, 1, din_init[1], typ_init[1], 1'b0, "mrst.re");

        // Randomized traffic against a transaction-level round-robin model.
        reset_pulse("rnd.rst");
        ptr_m = 0;
        for (int n = 0; n < 60; n++) begin
            new_bits = 4'($urandom_range(0, 15)) & ~req_v;
            if ($urandom_range(0, 3) == 0) new_bits = 4'b0000;
            for (int i = 0; i < N; i++) begin
                if (new_bits[i]) begin
                    din_arr[i] = $urandom;
                    typ_v[i]   = 1'($urandom_range(0, 1));
                end
            end
            req_v = req_v | new_bits;
            if (req_v == 4'b0000) begin
                step();
                chk($sformatf("r%0d.idle.req_tx", n), 64'(req_tx), 64'd0);
                chk($sformatf("r%0d.idle.busy", n),   64'(busy),   64'd0);
            end else begin
                found = 1'b0;
                win   = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_v[(ptr_m + k) % N]) begin
                        found = 1'b1;
                        win   = (ptr_m + k) % N;
                    end
                end
                dly = $urandom_range(0, 20);
                grant(win, din_arr[win], typ_v[win], $sformatf("r%0d", n));
                complete(dly, win, din_arr[win], typ_v[win], dly >= TIMEOUT, $sformatf("r%0d", n));
                ptr_m = (win + 1) % N;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
